// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, 8N1 frame constants and the
// sample-tick divider formula used by both receiver and transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } uart_state_e;

    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;
    localparam int STOP_BITS  = 1;

    // Integer truncation; the residual baud error is absorbed by mid-bit voting.
    function automatic int tick_div(input int clk_freq, input int baud_rate);
        return clk_freq / (baud_rate * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Free-running sample-tick divider with synchronous clear; tick_o is high for
// one clock when the counter reaches DIV-1.
module uart_tick_gen #(
    parameter int DIV = 325,
    parameter int W   = 9
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == LAST) && !clr_i;

    always_comb begin
        cnt_d = cnt_q + W'(1);
        if (clr_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rx_uart.sv
// 8N1 UART receiver: 2-flop synchronizer, 16x oversampling with a 3-sample
// majority vote, writes good bytes to a FIFO and pulses frame/overrun errors.
module rx_uart
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxData,
    output logic [7:0] din,
    output logic       wrEn,
    input  logic       full,
    output logic       frameErr,
    output logic       overrun,
    output logic       rxBusy
);

    localparam int         TICK_DIV = tick_div(CLK_FREQ, BAUD_RATE);
    localparam logic [3:0] VOTE_A   = 4'd7;
    localparam logic [3:0] VOTE_B   = 4'd8;
    localparam logic [3:0] DECIDE   = 4'd9;
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    logic        sync1_q, rx_s_q;
    uart_state_e state_q;
    logic [3:0]  samp_q;
    logic [2:0]  bit_q;
    logic [1:0]  votes_q;
    logic [7:0]  shift_q;
    logic [7:0]  din_q;
    logic        wr_en_q, frame_err_q, overrun_q, busy_q;
    logic        tick, start_det, decide, vote;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= rxData;
            rx_s_q  <= sync1_q;
        end
    end

    // Restarting the divider on the start edge phase-aligns sampling to the frame.
    assign start_det = (state_q == ST_IDLE) && !rx_s_q;

    uart_tick_gen #(
        .DIV (TICK_DIV),
        .W   (9)
    ) u_tick_gen (
        .clk_i  (clk),
        .rst_i  (rst),
        .clr_i  (start_det),
        .tick_o (tick)
    );

    assign decide = tick && (samp_q == DECIDE);
    assign vote   = (votes_q[0] & votes_q[1]) | (votes_q[0] & rx_s_q) | (votes_q[1] & rx_s_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            samp_q      <= '0;
            bit_q       <= '0;
            votes_q     <= '0;
            shift_q     <= '0;
            din_q       <= '0;
            wr_en_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            wr_en_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;

            if (start_det) begin
                samp_q <= '0;
            end else if (tick) begin
                samp_q <= samp_q + 4'd1;
            end
            if (tick && (samp_q == VOTE_A)) votes_q[0] <= rx_s_q;
            if (tick && (samp_q == VOTE_B)) votes_q[1] <= rx_s_q;

            case (state_q)
                ST_IDLE: begin
                    if (!rx_s_q) begin
                        state_q <= ST_START;
                        bit_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (decide) begin
                        if (!vote) begin
                            state_q <= ST_DATA;
                            bit_q   <= '0;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                ST_DATA: begin
                    if (decide) begin
                        shift_q <= {vote, shift_q[7:1]};
                        if (bit_q == LAST_BIT) begin
                            state_q <= ST_STOP;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if (decide) begin
                        if (!vote) begin
                            frame_err_q <= 1'b1;
                            state_q     <= ST_WAIT_HIGH;
                        end else begin
                            // Leaving mid stop bit lets a back-to-back start edge be caught.
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                            if (full) begin
                                overrun_q <= 1'b1;
                            end else begin
                                din_q   <= shift_q;
                                wr_en_q <= 1'b1;
                            end
                        end
                    end
                end
                ST_WAIT_HIGH: begin
                    if (rx_s_q) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign din      = din_q;
    assign wrEn     = wr_en_q;
    assign frameErr = frame_err_q;
    assign overrun  = overrun_q;
    assign rxBusy   = busy_q;

endmodule

// File: tb/tb_rx_uart.sv
// Directed bench for rx_uart at a scaled baud rate (TICK_DIV=5, 80 clk per bit);
// a negedge monitor logs writes and error pulses, checks compare against hand values.
module tb_rx_uart;

    localparam int CLK_FREQ  = 50_000_000;
    localparam int BAUD_RATE = 625_000;
    localparam int CLK_T     = 20;
    localparam int BIT_T     = 1600;      // 16 ticks * 5 clk * 20
    localparam int BIT_FAST  = 1568;      // line 2% fast
    localparam int BIT_SLOW  = 1632;      // line 2% slow
    localparam int LAT_EXP   = 772;       // 2 + 9*16*5 + 10*5

    logic       clk;
    logic       rst;
    logic       rxData;
    logic [7:0] din;
    logic       wrEn;
    logic       full;
    logic       frameErr;
    logic       overrun;
    logic       rxBusy;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_wr     = 0;
    int         n_fe     = 0;
    int         n_ov     = 0;
    int         n_excl   = 0;
    logic [7:0] got_q[$];
    longint     t_fall   = 0;
    longint     t_wr     = 0;
    int         wr_base, fe_base, ov_base;

    rx_uart #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rxData   (rxData),
        .din      (din),
        .wrEn     (wrEn),
        .full     (full),
        .frameErr (frameErr),
        .overrun  (overrun),
        .rxBusy   (rxBusy)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (wrEn) begin
                n_wr++;
                got_q.push_back(din);
                t_wr = $time;
            end
            if (frameErr) n_fe++;
            if (overrun) n_ov++;
            if ((int'(wrEn) + int'(frameErr) + int'(overrun)) > 1) n_excl++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic mark();
        wr_base = n_wr;
        fe_base = n_fe;
        ov_base = n_ov;
    endtask

    // Leaves the line at the stop-bit level when done.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int bit_t);
        t_fall = $time;
        rxData = 1'b0;
        #(bit_t);
        for (int i = 0; i < 8; i++) begin
            rxData = b[i];
            #(bit_t);
        end
        rxData = stop_bit;
        #(bit_t);
    endtask

    function automatic logic [7:0] got_at(input int idx);
        if (idx < got_q.size()) return got_q[idx];
        return 8'hxx;
    endfunction

    initial begin
        logic [7:0] c3;
        longint     lat;

        rst    = 1'b1;
        rxData = 1'b1;
        full   = 1'b0;
        idle(5);
        check("rst_din", din, 8'h00);
        check("rst_wren", wrEn, 1'b0);
        check("rst_ferr", frameErr, 1'b0);
        check("rst_ovr", overrun, 1'b0);
        check("rst_busy", rxBusy, 1'b0);
        rst = 1'b0;
        idle(20);

        // single byte and write latency
        mark();
        send_frame(8'h55, 1'b1, BIT_T);
        idle(40);
        check("b55_nwr", n_wr - wr_base, 1);
        check("b55_din", got_at(wr_base), 8'h55);
        lat = (t_wr - t_fall) / CLK_T;
        check("b55_latency_ok", (lat >= LAT_EXP - 1 && lat <= LAT_EXP + 1), 1'b1);
        check("b55_ferr", n_fe - fe_base, 0);
        check("b55_ovr", n_ov - ov_base, 0);
        check("b55_busy_end", rxBusy, 1'b0);

        // back-to-back, no idle bits
        mark();
        send_frame(8'h00, 1'b1, BIT_T);
        send_frame(8'hFF, 1'b1, BIT_T);
        send_frame(8'hA5, 1'b1, BIT_T);
        idle(40);
        check("b2b_nwr", n_wr - wr_base, 3);
        check("b2b_d0", got_at(wr_base), 8'h00);
        check("b2b_d1", got_at(wr_base + 1), 8'hFF);
        check("b2b_d2", got_at(wr_base + 2), 8'hA5);
        check("b2b_err", (n_fe - fe_base) + (n_ov - ov_base), 0);

        // short low glitch on an idle line
        mark();
        rxData = 1'b0;
        idle(10);
        check("glitch_busy_hi", rxBusy, 1'b1);
        rxData = 1'b1;
        idle(80);
        check("glitch_busy_lo", rxBusy, 1'b0);
        check("glitch_nwr", n_wr - wr_base, 0);
        check("glitch_err", (n_fe - fe_base) + (n_ov - ov_base), 0);

        // framing error followed by a break, then a good byte
        mark();
        send_frame(8'h3C, 1'b0, BIT_T);
        #(2 * BIT_T);
        check("brk_busy_hi", rxBusy, 1'b1);
        rxData = 1'b1;
        idle(20);
        check("ferr_cnt", n_fe - fe_base, 1);
        check("ferr_nwr", n_wr - wr_base, 0);
        check("ferr_busy_lo", rxBusy, 1'b0);
        mark();
        send_frame(8'h81, 1'b1, BIT_T);
        idle(40);
        check("b81_nwr", n_wr - wr_base, 1);
        check("b81_din", got_at(wr_base), 8'h81);
        check("b81_ferr", n_fe - fe_base, 0);

        // overrun while FIFO full
        mark();
        full = 1'b1;
        send_frame(8'h7E, 1'b1, BIT_T);
        full = 1'b0;
        idle(40);
        check("ovr_cnt", n_ov - ov_base, 1);
        check("ovr_nwr", n_wr - wr_base, 0);
        check("ovr_din_kept", din, 8'h81);
        mark();
        send_frame(8'h12, 1'b1, BIT_T);
        idle(40);
        check("b12_nwr", n_wr - wr_base, 1);
        check("b12_din", got_at(wr_base), 8'h12);

        // reset in the middle of a frame
        mark();
        c3 = 8'hC3;
        rxData = 1'b0;
        #(BIT_T);
        for (int i = 0; i < 4; i++) begin
            rxData = c3[i];
            #(BIT_T);
        end
        rxData = c3[4];
        #(BIT_T / 2);
        check("mid_busy_hi", rxBusy, 1'b1);
        rst = 1'b1;
        rxData = 1'b1;
        idle(3);
        check("mrst_din", din, 8'h00);
        check("mrst_busy", rxBusy, 1'b0);
        check("mrst_pulses", {wrEn, frameErr, overrun}, 3'b000);
        idle(2);
        rst = 1'b0;
        idle(200);
        send_frame(8'h96, 1'b1, BIT_T);
        idle(40);
        check("b96_nwr", n_wr - wr_base, 1);
        check("b96_din", got_at(wr_base), 8'h96);
        check("b96_err", (n_fe - fe_base) + (n_ov - ov_base), 0);

        // baud tolerance
        mark();
        send_frame(8'h5A, 1'b1, BIT_FAST);
        idle(40);
        send_frame(8'h5A, 1'b1, BIT_SLOW);
        idle(40);
        check("tol_nwr", n_wr - wr_base, 2);
        check("tol_fast_din", got_at(wr_base), 8'h5A);
        check("tol_slow_din", got_at(wr_base + 1), 8'h5A);
        check("tol_err", (n_fe - fe_base) + (n_ov - ov_base), 0);

        check("pulse_exclusive", n_excl, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
